// File: rtl/shared_byte_arbiter.sv
// shared_byte_arbiter
//
// Arbitrates two byte-wide, nibble-laned write requesters onto one shared
// 8-bit register. Requests with disjoint lanes are merged and granted together.
// Overlapping requests are granted to one side: the current owner wins until it
// has taken MAX_BURST consecutive exclusive grants, then the other side wins.
//
// Ports
//   i_clk                    clock, rising edge
//   i_rst_n                  asynchronous active-low reset
//   i_req0/i_lane0/i_data0   requester 0: request, lane enables, write data
//   i_req1/i_lane1/i_data1   requester 1: request, lane enables, write data
//   o_gnt0/o_gnt1            combinational grants; the write commits at the next edge
//   o_x                      registered shared vector
//   o_owner                  registered owner state: 00 idle, 01 own0, 10 own1
//   o_burst                  registered consecutive-grant count of the current owner

module shared_byte_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_req0,
  input  logic [1:0] i_lane0,
  input  logic [7:0] i_data0,
  input  logic       i_req1,
  input  logic [1:0] i_lane1,
  input  logic [7:0] i_data1,
  output logic       o_gnt0,
  output logic       o_gnt1,
  output logic [7:0] o_x,
  output logic [1:0] o_owner,
  output logic [3:0] o_burst
);

  localparam logic [3:0] BurstMax = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOwn0 = 2'b01,
    StOwn1 = 2'b10
  } state_e;

  state_e     state_q;
  logic [3:0] burst_q;
  logic [7:0] x_q;
  logic [7:0] x_d;

  logic both_req;
  logic overlap;
  logic merge;
  logic burst_full;
  logic pick1;
  logic gnt0;
  logic gnt1;

  // Overwrite only the nibbles whose lane bit is set.
  function automatic logic [7:0] lane_write(input logic [7:0] cur, input logic [1:0] lane,
                                            input logic [7:0] data);
    logic [7:0] res;
    res = cur;
    if (lane[0]) res[3:0] = data[3:0];
    if (lane[1]) res[7:4] = data[7:4];
    return res;
  endfunction

  // Grant decode
  always_comb begin
    both_req   = i_req0 & i_req1;
    overlap    = |(i_lane0 & i_lane1);
    merge      = both_req & ~overlap;
    burst_full = (burst_q >= BurstMax);

    // Conflict winner: the owner keeps the bus until its burst is used up.
    // Idle (and the unused encoding) favours requester 0.
    case (state_q)
      StOwn0:  pick1 = burst_full;
      StOwn1:  pick1 = ~burst_full;
      default: pick1 = 1'b0;
    endcase

    gnt0 = i_req0 & ~(both_req & ~merge & pick1);
    gnt1 = i_req1 & ~(both_req & ~merge & ~pick1);

    // Merged grants have disjoint lanes, so applying both in sequence is safe.
    x_d = x_q;
    if (gnt0) x_d = lane_write(x_d, i_lane0, i_data0);
    if (gnt1) x_d = lane_write(x_d, i_lane1, i_data1);
  end

  // Owner FSM, burst counter and shared vector
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      burst_q <= '0;
      x_q     <= '0;
    end else begin
      x_q <= x_d;
      if (merge) begin
        // Merged cycle: owner is kept but its exclusive run is broken.
        burst_q <= '0;
      end else if (gnt0) begin
        if (state_q == StOwn0) begin
          if (!burst_full) burst_q <= burst_q + 4'd1;
        end else begin
          state_q <= StOwn0;
          burst_q <= 4'd1;
        end
      end else if (gnt1) begin
        if (state_q == StOwn1) begin
          if (!burst_full) burst_q <= burst_q + 4'd1;
        end else begin
          state_q <= StOwn1;
          burst_q <= 4'd1;
        end
      end else begin
        state_q <= StIdle;
        burst_q <= '0;
      end
    end
  end

  // Grants are forced low while reset is asserted.
  assign o_gnt0  = gnt0 & i_rst_n;
  assign o_gnt1  = gnt1 & i_rst_n;
  assign o_x     = x_q;
  assign o_owner = state_q;
  assign o_burst = burst_q;

endmodule

// File: tb/tb_shared_byte_arbiter.sv
module tb_shared_byte_arbiter;

  localparam int MB = 4;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [1:0] lane0, lane1;
  logic [7:0] data0, data1;
  logic       gnt0, gnt1;
  logic [7:0] x;
  logic [1:0] owner;
  logic [3:0] burst;

  int n_checks;
  int n_fail;
  logic chk_en;
  int w0, w1;

  shared_byte_arbiter #(.MAX_BURST(MB)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_req0 (req0),
    .i_lane0(lane0),
    .i_data0(data0),
    .i_req1 (req1),
    .i_lane1(lane1),
    .i_data1(data1),
    .o_gnt0 (gnt0),
    .o_gnt1 (gnt1),
    .o_x    (x),
    .o_owner(owner),
    .o_burst(burst)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // owner: -1 nobody, 0 or 1 = requester index
  typedef struct packed {
    int         owner;
    int         burst;
    logic [7:0] x;
    logic       g0;
    logic       g1;
  } mstate_t;

  mstate_t m;

  // Returns {g1, g0} for the given model state and requests.
  function automatic logic [1:0] exp_gnt(input int own, input int b, input logic r0,
                                         input logic [1:0] l0, input logic r1,
                                         input logic [1:0] l1);
    int win;
    if (r0 && r1) begin
      if ((l0 & l1) == 2'b00) return 2'b11;
      if (own < 0) win = 0;
      else if (b < MB) win = own;
      else win = 1 - own;
      return (win == 0) ? 2'b01 : 2'b10;
    end
    return {r1, r0};
  endfunction

  function automatic logic [7:0] apply(input logic [7:0] cur, input logic [1:0] l,
                                       input logic [7:0] d);
    logic [7:0] r;
    r = cur;
    for (int n = 0; n < 2; n++) if (l[n]) r[4*n +: 4] = d[4*n +: 4];
    return r;
  endfunction

  function automatic logic [1:0] enc_owner(input int own);
    if (own < 0) return 2'b00;
    return (own == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic r0, input logic [1:0] l0,
                                   input logic [7:0] d0, input logic r1,
                                   input logic [1:0] l1, input logic [7:0] d1);
    mstate_t    n;
    logic [1:0] g;
    int         who;
    n = s;
    g = exp_gnt(s.owner, s.burst, r0, l0, r1, l1);
    if (g[0]) n.x = apply(n.x, l0, d0);
    if (g[1]) n.x = apply(n.x, l1, d1);
    if (g == 2'b11) begin
      n.burst = 0;
    end else if (g != 2'b00) begin
      who = g[1] ? 1 : 0;
      if (s.owner == who) n.burst = (s.burst < MB) ? s.burst + 1 : MB;
      else begin
        n.owner = who;
        n.burst = 1;
      end
    end else begin
      n.owner = -1;
      n.burst = 0;
    end
    n.g0 = g[0];
    n.g1 = g[1];
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{owner: -1, burst: 0, x: 8'h00, g0: 1'b0, g1: 1'b0};
    else        m <= step(m, req0, lane0, data0, req1, lane1, data1);
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle outside reset, DUT vs model.
  always @(negedge clk) begin
    logic [1:0] eg;
    if (chk_en && rst_n) begin
      eg = exp_gnt(m.owner, m.burst, req0, lane0, req1, lane1);
      chk("model gnt0", 8'(gnt0), 8'(eg[0]));
      chk("model gnt1", 8'(gnt1), 8'(eg[1]));
      chk("model x", x, m.x);
      chk("model owner", 8'(owner), 8'(enc_owner(m.owner)));
      chk("model burst", 8'(burst), 8'(m.burst));
      // Bounded wait: at most MB ungranted cycles before the grant cycle.
      if (req0 && !gnt0) w0++;
      else if (req0) begin
        chk("wait0 bound", 8'(w0 > MB), 8'h00);
        w0 = 0;
      end else w0 = 0;
      if (req1 && !gnt1) w1++;
      else if (req1) begin
        chk("wait1 bound", 8'(w1 > MB), 8'h00);
        w1 = 0;
      end else w1 = 0;
    end
  end

  task automatic drive(input logic r0, input logic [1:0] l0, input logic [7:0] d0,
                       input logic r1, input logic [1:0] l1, input logic [7:0] d1);
    req0 = r0; lane0 = l0; data0 = d0;
    req1 = r1; lane1 = l1; data1 = d1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string name, input logic [7:0] ex, input logic [1:0] eo,
                          input logic [3:0] eb);
    chk({name, " x"}, x, ex);
    chk({name, " owner"}, 8'(owner), 8'(eo));
    chk({name, " burst"}, 8'(burst), 8'(eb));
  endtask

  // Pulse reset between edges (called at posedge+1) and check outputs at once.
  task automatic reset_pulse(input string name);
    #1 rst_n = 1'b0;
    #1;
    chk_regs(name, 8'h00, 2'b00, 4'd0);
    chk({name, " gnt0"}, 8'(gnt0), 8'h00);
    chk({name, " gnt1"}, 8'(gnt1), 8'h00);
    w0 = 0;
    w1 = 0;
    rst_n = 1'b1;
  endtask

  int gpat [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
  int bseq [10] = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2};
  int sat  [6]  = '{1, 2, 3, 4, 4, 4};

  initial begin
    logic       p0, p1;
    logic [1:0] rl0, rl1;
    logic [7:0] rd0, rd1;

    clk = 1'b0; rst_n = 1'b0; chk_en = 1'b0;
    n_checks = 0; n_fail = 0; w0 = 0; w1 = 0;
    drive(0, 2'b00, 8'h00, 0, 2'b00, 8'h00);

    // Reset state, with a request present
    #2 drive(1, 2'b11, 8'hAB, 1, 2'b01, 8'h12);
    #1;
    chk_regs("reset", 8'h00, 2'b00, 4'd0);
    chk("reset gnt0", 8'(gnt0), 8'h00);
    chk("reset gnt1", 8'(gnt1), 8'h00);
    drive(0, 2'b00, 8'h00, 0, 2'b00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // Merge from idle
    drive(1, 2'b01, 8'h00, 1, 2'b10, 8'hFF);
    @(negedge clk);
    chk("merge gnt0", 8'(gnt0), 8'h01);
    chk("merge gnt1", 8'(gnt1), 8'h01);
    tick();
    chk_regs("merge", 8'hF0, 2'b00, 4'd0);

    // Conflict from idle, then requester 1 alone
    drive(1, 2'b11, 8'hAA, 1, 2'b11, 8'h55);
    @(negedge clk);
    chk("conflict gnt0", 8'(gnt0), 8'h01);
    chk("conflict gnt1", 8'(gnt1), 8'h00);
    tick();
    chk_regs("conflict", 8'hAA, 2'b01, 4'd1);
    req0 = 1'b0;
    @(negedge clk);
    chk("handover gnt1", 8'(gnt1), 8'h01);
    tick();
    chk_regs("handover", 8'h55, 2'b10, 4'd1);
    drive(0, 2'b00, 8'h00, 0, 2'b00, 8'h00);
    tick();
    chk_regs("idle", 8'h55, 2'b00, 4'd0);

    // Fairness under continuous conflict
    drive(1, 2'b11, 8'h0F, 1, 2'b11, 8'hF0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("fair gnt0", 8'(gnt0), 8'(gpat[i] == 0));
      chk("fair gnt1", 8'(gnt1), 8'(gpat[i] == 1));
      tick();
      chk("fair burst", 8'(burst), 8'(bseq[i]));
    end
    drive(0, 2'b00, 8'h00, 0, 2'b00, 8'h00);
    tick();

    // Saturation with a single requester, then a conflicting newcomer
    drive(1, 2'b11, 8'h99, 0, 2'b00, 8'h00);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("sat gnt0", 8'(gnt0), 8'h01);
      tick();
      chk("sat burst", 8'(burst), 8'(sat[i]));
    end
    drive(1, 2'b11, 8'h99, 1, 2'b10, 8'h66);
    @(negedge clk);
    chk("sat gnt1", 8'(gnt1), 8'h01);
    chk("sat gnt0 lose", 8'(gnt0), 8'h00);
    tick();
    chk_regs("sat handover", 8'h69, 2'b10, 4'd1);
    drive(0, 2'b00, 8'h00, 0, 2'b00, 8'h00);
    tick();

    // Partial lane and empty-lane writes
    drive(1, 2'b11, 8'h3C, 0, 2'b00, 8'h00);
    tick();
    chk("lane x 3C", x, 8'h3C);
    drive(0, 2'b00, 8'h00, 1, 2'b01, 8'hF7);
    tick();
    chk("lane x 37", x, 8'h37);
    drive(1, 2'b00, 8'hFF, 0, 2'b00, 8'h00);
    @(negedge clk);
    chk("lane00 gnt0", 8'(gnt0), 8'h01);
    tick();
    chk("lane00 x", x, 8'h37);
    drive(0, 2'b00, 8'h00, 0, 2'b00, 8'h00);
    tick();

    // Reset mid-burst
    drive(0, 2'b00, 8'h00, 1, 2'b11, 8'h5A);
    repeat (3) tick();
    chk_regs("preburst", 8'h5A, 2'b10, 4'd3);
    drive(1, 2'b11, 8'h11, 1, 2'b11, 8'h5A);
    reset_pulse("midburst rst");
    @(negedge clk);
    chk("post rst gnt0", 8'(gnt0), 8'h01);
    chk("post rst gnt1", 8'(gnt1), 8'h00);
    tick();
    chk_regs("post rst", 8'h11, 2'b01, 4'd1);
    drive(0, 2'b00, 8'h00, 0, 2'b00, 8'h00);
    tick();

    // Randomized traffic obeying the hold-until-granted protocol
    p0 = 0; p1 = 0; rl0 = 0; rl1 = 0; rd0 = 0; rd1 = 0;
    for (int c = 0; c < 2000; c++) begin
      if (p0 && m.g0) p0 = 0;
      if (p1 && m.g1) p1 = 0;
      if (!p0 && $urandom_range(0, 9) < 6) begin
        p0 = 1; rl0 = 2'($urandom_range(0, 3)); rd0 = 8'($urandom);
      end
      if (!p1 && $urandom_range(0, 9) < 6) begin
        p1 = 1; rl1 = 2'($urandom_range(0, 3)); rd1 = 8'($urandom);
      end
      drive(p0, rl0, rd0, p1, rl1, rd1);
      if ($urandom_range(0, 249) == 0) begin
        reset_pulse("random rst");
        p0 = 0; p1 = 0;
        drive(0, rl0, rd0, 0, rl1, rd1);
      end
      tick();
    end

    drive(0, 2'b00, 8'h00, 0, 2'b00, 8'h00);
    tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_byte_arbiter.md
SHARED_BYTE_ARBITER -- requirements
Module: shared_byte_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 4, SHALL set the maximum consecutive exclusive grants to one owner while the other requester is blocked (legal range 1..15).
REQ-002 i_clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 i_rst_n  input  1  SHALL be the reset, asynchronous assert, active-low.
REQ-004 i_req0  input  1  requester 0 write request, held until granted.
REQ-005 i_lane0  input  2  requester 0 lane enables: bit0 = x[3:0], bit1 = x[7:4].
REQ-006 i_data0  input  8  requester 0 write data, only enabled lanes used.
REQ-007 i_req1, i_lane1, i_data1  input  1/2/8  requester 1, same meaning as REQ-004..006.
REQ-008 o_gnt0  output  1  combinational; high in the cycle requester 0's write commits at the next edge.
REQ-009 o_gnt1  output  1  as o_gnt0 for requester 1.
REQ-010 o_x  output  8  registered shared vector.
REQ-011 o_owner  output  2  registered FSM state: 00 IDLE, 01 OWN0, 10 OWN1.
REQ-012 o_burst  output  4  registered consecutive-grant count of current owner.

Function
REQ-013 A requester SHALL keep req, lane and data stable from assertion until the cycle its gnt is high; the block SHALL NOT check this.
REQ-014 Merge: if i_req0 and i_req1 are both high and (i_lane0 & i_lane1) == 00, both gnt SHALL be high in the same cycle and both lane sets SHALL be written at the edge.
REQ-015 Merge SHALL leave o_owner unchanged and SHALL clear o_burst to 0.
REQ-016 Conflict: both requesting with overlapping lanes SHALL grant exactly one requester.
REQ-017 Conflict in IDLE SHALL grant requester 0.
REQ-018 Conflict in OWNk with o_burst < MAX_BURST SHALL grant requester k.
REQ-019 Conflict in OWNk with o_burst == MAX_BURST SHALL grant the other requester.
REQ-020 A single requester SHALL be granted in the same cycle regardless of state or o_burst.
REQ-021 A granted write SHALL update o_x nibble n from data bit range of nibble n only where lane bit n is 1; other nibbles SHALL hold.
REQ-022 A granted request with lane 00 SHALL complete the handshake and count as a grant with no change to o_x.
REQ-023 Exclusive grant to requester j while in IDLE or OWNk (k != j) SHALL move to OWNj and set o_burst to 1.
REQ-024 Exclusive grant to the current owner SHALL increment o_burst, saturating at MAX_BURST.
REQ-025 A cycle with neither request SHALL move to IDLE and clear o_burst to 0; o_x SHALL hold.
REQ-026 o_gnt0/o_gnt1 SHALL never both be high except under REQ-014.
REQ-027 Latency: write data SHALL appear on o_x one clock after the gnt cycle; no request SHALL wait more than MAX_BURST+1 cycles while continuously asserted.

Reset
REQ-028 While i_rst_n is low: o_x = 8'h00, o_owner = 00, o_burst = 0, o_gnt0 = o_gnt1 = 0, asynchronously.
REQ-029 Reset asserted mid-burst SHALL discard the ungranted request and current ownership; first cycle after deassertion SHALL arbitrate as from IDLE.

Verification
REQ-030 Merge: req0 lane 01 data 8'h00, req1 lane 10 data 8'hFF, same cycle -> both gnt high, o_x = 8'hF0 next cycle, o_owner unchanged, o_burst = 0.
REQ-031 Conflict from IDLE: both req, lanes 11, data0 = 8'hAA, data1 = 8'h55 -> gnt0 only, o_x = 8'hAA, o_owner = 01, o_burst = 1; next cycle gnt1 (req0 dropped), o_x = 8'h55, o_owner = 10.
REQ-032 Fairness, MAX_BURST = 4: req0 and req1 held with lanes 11 for 10 cycles -> grant pattern 0,0,0,0,1,1,1,1,0,0; o_burst sequence 1,2,3,4,1,2,3,4,1,2.
REQ-033 Saturation: only req0 held 6 cycles -> gnt0 every cycle, o_burst 1,2,3,4,4,4; then req1 added overlapping -> gnt1 next cycle.
REQ-034 Partial lane: o_x = 8'h3C, req1 lane 01 data 8'hF7 -> o_x = 8'h37; lane 00 request -> gnt high, o_x unchanged.
REQ-035 Reset: after o_x = 8'h5A, o_owner = 10, o_burst = 3, pulse i_rst_n low between edges -> outputs 0 immediately; after release with req0 and req1 overlapping, gnt0 wins.
